// File: rtl/rf_arb_pkg.sv
// Shared types and sizing for the register-file port arbiter.
// Geometry of the RF and the requester count live here.
package rf_arb_pkg;

  localparam int NUM_REQ   = 4;
  localparam int PHIT_SIZE = 32;
  localparam int ADDR_W    = 4;
  localparam int DEPTH_RF  = 12;

  typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;
  typedef logic [ADDR_W-1:0]          rf_addr_t;
  typedef logic [PHIT_SIZE-1:0]       phit_t;

  // One extra bit so a full-depth RF still compares correctly.
  localparam logic [ADDR_W:0] OOB_LIM =
    (ADDR_W+1)'(DEPTH_RF);

  function automatic logic is_oob(rf_addr_t a);
    return {1'b0, a} >= OOB_LIM;
  endfunction

endpackage

// File: rtl/rf_port_arbiter_if.sv
// Requester-side bundle of the RF port arbiter.
// master = requesters, slave = arbiter.
interface rf_port_arbiter_if
  import rf_arb_pkg::*;
();

  logic [NUM_REQ-1:0]    wr_valid;
  rf_addr_t [NUM_REQ-1:0] wr_addr;
  phit_t [NUM_REQ-1:0]    wr_data;
  logic [NUM_REQ-1:0]    wr_ready;
  logic [NUM_REQ-1:0]    rd_valid;
  rf_addr_t [NUM_REQ-1:0] rd_addr;
  logic [NUM_REQ-1:0]    rd_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  phit_t                 rsp_data;
  logic                  oob_err;

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_valid, rd_addr,
    input  wr_ready, rd_ready,
    input  rsp_valid, rsp_data, oob_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_valid, rd_addr,
    output wr_ready, rd_ready,
    output rsp_valid, rsp_data, oob_err
  );

endinterface

// File: rtl/rf_port_arbiter_rr_arb.sv
// Round-robin arbiter: valid vector to one-hot grant.
// Pointer advances past the winner; holds when idle.
module rr_arb
  import rf_arb_pkg::*;
#(
  parameter int N = NUM_REQ
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         valid,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] sel;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      sel = IW'((int'(ptr_q) + k) % N);
      if (rst_n && !any && valid[sel]) begin
        any = 1'b1;
        idx = sel;
      end
    end
    if (any) grant[idx] = 1'b1;
    ptr_d = ptr_q;
    if (any) begin
      ptr_d = (int'(idx) == N-1) ? '0
                                 : idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares a 1W/1R register file between requesters.
// Define RF_FWD_EN for write-first same-address reads.
module rf_port_arbiter
  import rf_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  rf_port_arbiter_if.slave   req,
  output logic               rf_wen,
  output rf_addr_t           rf_wr_addr,
  output phit_t              rf_d_in,
  output rf_addr_t           rf_rd_addr,
  input  phit_t              rf_d_out
);

  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  req_idx_t           wr_idx, rd_idx;
  logic               wr_any, rd_any;
  logic               wr_oob, rd_oob;
  phit_t              rd_val;

  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  phit_t              rsp_data_q, rsp_data_d;
  logic               oob_err_q, oob_err_d;

  rr_arb #(.N(NUM_REQ)) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (req.wr_valid),
    .grant (wr_gnt),
    .idx   (wr_idx),
    .any   (wr_any)
  );

  rr_arb #(.N(NUM_REQ)) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (req.rd_valid),
    .grant (rd_gnt),
    .idx   (rd_idx),
    .any   (rd_any)
  );

  always_comb begin
    rf_wr_addr = wr_any ? req.wr_addr[wr_idx] : '0;
    rf_d_in    = wr_any ? req.wr_data[wr_idx] : '0;
    rf_rd_addr = rd_any ? req.rd_addr[rd_idx] : '0;
    wr_oob     = wr_any && is_oob(rf_wr_addr);
    rd_oob     = rd_any && is_oob(rf_rd_addr);
    rf_wen     = wr_any && !wr_oob;
    rd_val     = rf_d_out;
`ifdef RF_FWD_EN
    if (rf_wen && rf_wr_addr == rf_rd_addr)
      rd_val = rf_d_in;
`endif
    rsp_data_d = rsp_data_q;
    if (rd_any) rsp_data_d = rd_oob ? '0 : rd_val;
    rsp_valid_d = rd_gnt;
    oob_err_d   = wr_oob || rd_oob;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      oob_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      oob_err_q   <= oob_err_d;
    end
  end

  assign req.wr_ready  = wr_gnt;
  assign req.rd_ready  = rd_gnt;
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_data  = rsp_data_q;
  assign req.oob_err   = oob_err_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: directed table, corner
// sequences, then random traffic against a reference model.
module tb_rf_port_arbiter;
  import rf_arb_pkg::*;

`ifdef RF_FWD_EN
  localparam bit          FWD    = 1'b1;
  localparam logic [31:0] ROW3_D = 32'h55;
`else
  localparam bit          FWD    = 1'b0;
  localparam logic [31:0] ROW3_D = 32'h11;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rf_port_arbiter_if bus();

  logic     rf_wen;
  rf_addr_t rf_wr_addr, rf_rd_addr;
  phit_t    rf_d_in, rf_d_out;

  rf_port_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (bus),
    .rf_wen     (rf_wen),
    .rf_wr_addr (rf_wr_addr),
    .rf_d_in    (rf_d_in),
    .rf_rd_addr (rf_rd_addr),
    .rf_d_out   (rf_d_out)
  );

  // Register file: combinational read, write at the edge.
  logic [31:0] rf_mem [16];
  logic        clr;
  always @(posedge clk) begin
    if (clr) begin
      for (int a = 0; a < 16; a++) rf_mem[a] <= '0;
    end else if (rf_wen) begin
      rf_mem[rf_wr_addr] <= rf_d_in;
    end
  end
  assign rf_d_out = rf_mem[rf_rd_addr];

  int passed = 0;
  int total  = 0;

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  typedef struct {
    logic [3:0]   wv;
    logic [15:0]  wa;
    logic [127:0] wd;
    logic [3:0]   rv;
    logic [15:0]  ra;
    logic [3:0]   e_wrdy;
    logic [3:0]   e_rrdy;
    logic         e_wen;
    logic [3:0]   e_rspv;
    logic [31:0]  e_rspd;
    logic         e_oob;
  } vec_t;

  function automatic logic [15:0] pa(int i, int a);
    return 16'(a) << (4*i);
  endfunction

  function automatic logic [127:0] pd(int i, int d);
    return 128'(d) << (32*i);
  endfunction

  function automatic vec_t mk(
    logic [3:0] wv, logic [15:0] wa, logic [127:0] wd,
    logic [3:0] rv, logic [15:0] ra,
    logic [3:0] ew, logic [3:0] er, logic en,
    logic [3:0] sv, logic [31:0] sd, logic oo);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd;
    v.rv = rv; v.ra = ra;
    v.e_wrdy = ew; v.e_rrdy = er; v.e_wen = en;
    v.e_rspv = sv; v.e_rspd = sd; v.e_oob = oo;
    return v;
  endfunction

  // Reference model state
  int          m_wptr, m_rptr;
  logic [31:0] ref_mem [16];
  logic [31:0] m_rsp_d;

  function automatic int winner(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++)
      if (v[(p+k)%4]) return (p+k)%4;
    return -1;
  endfunction

  task automatic idle_inputs();
    bus.wr_valid = '0; bus.wr_addr = '0;
    bus.wr_data  = '0; bus.rd_valid = '0;
    bus.rd_addr  = '0;
  endtask

  task automatic model_cycle(output int w, output int r);
    logic [3:0]  ew, er;
    logic        wo, ro, en;
    int          wa, ra;
    logic [31:0] wd, rd;
    #1;
    w  = winner(bus.wr_valid, m_wptr);
    r  = winner(bus.rd_valid, m_rptr);
    ew = (w >= 0) ? 4'(1 << w) : 4'b0;
    er = (r >= 0) ? 4'(1 << r) : 4'b0;
    wa = (w >= 0) ? int'(bus.wr_addr[w]) : 0;
    wd = (w >= 0) ? bus.wr_data[w] : 32'h0;
    ra = (r >= 0) ? int'(bus.rd_addr[r]) : 0;
    wo = (w >= 0) && wa >= DEPTH_RF;
    ro = (r >= 0) && ra >= DEPTH_RF;
    en = (w >= 0) && !wo;
    rd = m_rsp_d;
    if (r >= 0) begin
      if (ro) rd = 0;
      else if (FWD && en && wa == ra) rd = wd;
      else rd = ref_mem[ra];
    end
    chk("rnd_wr_ready", 128'(bus.wr_ready), 128'(ew));
    chk("rnd_rd_ready", 128'(bus.rd_ready), 128'(er));
    chk("rnd_rf_wen", 128'(rf_wen), 128'(en));
    chk("rnd_rf_rd_addr", 128'(rf_rd_addr), 128'(ra));
    if (en) begin
      chk("rnd_rf_wr_addr", 128'(rf_wr_addr), 128'(wa));
      chk("rnd_rf_d_in", 128'(rf_d_in), 128'(wd));
    end
    @(posedge clk);
    #1;
    chk("rnd_rsp_valid", 128'(bus.rsp_valid), 128'(er));
    chk("rnd_rsp_data", 128'(bus.rsp_data), 128'(rd));
    chk("rnd_oob_err", 128'(bus.oob_err),
        128'(wo || ro));
    if (en) ref_mem[wa] = wd;
    m_rsp_d = rd;
    if (w >= 0) m_wptr = (w + 1) % 4;
    if (r >= 0) m_rptr = (r + 1) % 4;
    @(negedge clk);
  endtask

  vec_t vecs [17];

  initial begin
    int w, r;
    rst_n = 1'b0;
    clr   = 1'b1;
    idle_inputs();
    bus.wr_valid = 4'hF;
    bus.rd_valid = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_wr_ready", 128'(bus.wr_ready), 0);
    chk("rst_rd_ready", 128'(bus.rd_ready), 0);
    chk("rst_rsp_valid", 128'(bus.rsp_valid), 0);
    chk("rst_rsp_data", 128'(bus.rsp_data), 0);
    chk("rst_oob_err", 128'(bus.oob_err), 0);
    idle_inputs();
    clr   = 1'b0;
    rst_n = 1'b1;

    vecs[0] = mk(4'b0001, pa(0,3), pd(0,'hA5), 0, 0,
                 4'b0001, 0, 1, 0, 0, 0);
    vecs[1] = mk(0, 0, 0, 4'b0100, pa(2,3),
                 0, 4'b0100, 0, 4'b0100, 'hA5, 0);
    vecs[2] = mk(4'b0010, pa(1,7), pd(1,'h11), 0, 0,
                 4'b0010, 0, 1, 0, 'hA5, 0);
    vecs[3] = mk(4'b0010, pa(1,7), pd(1,'h55),
                 4'b1000, pa(3,7), 4'b0010, 4'b1000, 1,
                 4'b1000, ROW3_D, 0);
    vecs[4] = mk(4'b0001, pa(0,12), pd(0,'hEE),
                 4'b0001, pa(0,12), 4'b0001, 4'b0001, 0,
                 4'b0001, 0, 1);
    vecs[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      vecs[6+i] = mk(4'b0100, pa(2,5),
                     pd(2, 'h22 + 'h11*i), 0, 0,
                     4'b0100, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      vecs[9+i] = mk(4'hF, 16'hBA98,
                     {32'h83, 32'h82, 32'h81, 32'h80},
                     0, 0, 4'(1 << ((i+3)%4)), 0, 1,
                     0, 0, 0);
    vecs[13] = mk(0, 0, 0, 4'hF, 16'h8573, 0, 4'b0010,
                  0, 4'b0010, 'h55, 0);
    vecs[14] = mk(0, 0, 0, 4'hF, 16'h8573, 0, 4'b0100,
                  0, 4'b0100, 'h44, 0);
    vecs[15] = mk(0, 0, 0, 4'hF, 16'h8573, 0, 4'b1000,
                  0, 4'b1000, 'h80, 0);
    vecs[16] = mk(0, 0, 0, 4'hF, 16'h8573, 0, 4'b0001,
                  0, 4'b0001, 'hA5, 0);

    for (int i = 0; i < 17; i++) begin
      bus.wr_valid = vecs[i].wv;
      bus.wr_addr  = vecs[i].wa;
      bus.wr_data  = vecs[i].wd;
      bus.rd_valid = vecs[i].rv;
      bus.rd_addr  = vecs[i].ra;
      #1;
      chk($sformatf("v%0d_wr_ready", i),
          128'(bus.wr_ready), 128'(vecs[i].e_wrdy));
      chk($sformatf("v%0d_rd_ready", i),
          128'(bus.rd_ready), 128'(vecs[i].e_rrdy));
      chk($sformatf("v%0d_rf_wen", i),
          128'(rf_wen), 128'(vecs[i].e_wen));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rsp_valid", i),
          128'(bus.rsp_valid), 128'(vecs[i].e_rspv));
      chk($sformatf("v%0d_rsp_data", i),
          128'(bus.rsp_data), 128'(vecs[i].e_rspd));
      chk($sformatf("v%0d_oob_err", i),
          128'(bus.oob_err), 128'(vecs[i].e_oob));
      @(negedge clk);
    end

    // Reset arriving while a read is in flight.
    idle_inputs();
    bus.rd_valid = 4'b0001;
    bus.rd_addr  = pa(0,3);
    @(posedge clk);
    #1;
    chk("pre_rst_rsp_data", 128'(bus.rsp_data), 'hA5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_ready", 128'(bus.rd_ready), 0);
    chk("mid_rst_rsp_valid", 128'(bus.rsp_valid), 0);
    chk("mid_rst_rsp_data", 128'(bus.rsp_data), 0);
    @(posedge clk);
    #1;
    chk("post_rst_rsp_valid", 128'(bus.rsp_valid), 0);
    chk("post_rst_rsp_data", 128'(bus.rsp_data), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All requesters held valid: fair rotation from ptr 0.
    bus.wr_valid = 4'hF;
    bus.wr_addr  = 16'h3210;
    bus.wr_data  = {32'h4, 32'h3, 32'h2, 32'h1};
    bus.rd_valid = 4'hF;
    bus.rd_addr  = 16'h3210;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("rr%0d_wr_ready", c),
          128'(bus.wr_ready), 128'(1 << (c%4)));
      chk($sformatf("rr%0d_rd_ready", c),
          128'(bus.rd_ready), 128'(1 << (c%4)));
      @(negedge clk);
    end

    // Random traffic against the reference model.
    idle_inputs();
    rst_n = 1'b0;
    clr   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr   = 1'b0;
    rst_n = 1'b1;
    m_wptr  = 0;
    m_rptr  = 0;
    m_rsp_d = 0;
    for (int a = 0; a < 16; a++) ref_mem[a] = 0;
    for (int n = 0; n < 400; n++) begin
      model_cycle(w, r);
      for (int i = 0; i < 4; i++) begin
        if (!bus.wr_valid[i] || w == i) begin
          bus.wr_valid[i] = 1'($urandom);
          bus.wr_addr[i]  = 4'($urandom_range(0, 15));
          bus.wr_data[i]  = $urandom;
        end
        if (!bus.rd_valid[i] || r == i) begin
          bus.rd_valid[i] = 1'($urandom);
          bus.rd_addr[i]  = 4'($urandom_range(0, 15));
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
